fifo_rd_unpack_32to16: RTL and testbench
========================================

FIFO_RD_UNPACK_32TO16 -- requirements
Module: fifo_rd_unpack_32to16

Interface
REQ-001 SHALL have parameter RD_DEPTH_WIDTH, default 11, FIFO read-side depth width; rd_water_level is RD_DEPTH_WIDTH+1 bits.
REQ-002 SHALL have parameter START_LEVEL, default 16, minimum rd_water_level (32-bit words) required before reading starts.
REQ-003 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-004 rd_clk  input  1  sole clock, rising edge.
REQ-005 rd_rst  input  1  asynchronous active-high reset.
REQ-006 rd_en  output  1  read strobe to the 32-bit FIFO read port.
REQ-007 rd_data  input  32  FIFO read data, valid exactly 1 cycle after the rd_en cycle (no output register).
REQ-008 rd_empty  input  1  FIFO empty flag.
REQ-009 rd_water_level  input  RD_DEPTH_WIDTH+1  FIFO read-side occupancy in words.
REQ-010 flush  input  1  synchronous pulse; discards buffered data and returns to IDLE.
REQ-011 pix_ready  input  1  downstream accepts pix_data this cycle.
REQ-012 pix_valid  output  1  pix_data holds a valid 16-bit pixel.
REQ-013 pix_data  output  16  pixel, unpacked from 32-bit words.
REQ-014 running  output  1  high in state RUN.
REQ-015 underflow  output  1  sticky; set on first underflow event since reset or flush.
REQ-016 underflow_cnt  output  16  saturating count of underflow events.

Function
REQ-017 States SHALL be IDLE and RUN only.
REQ-018 IDLE->RUN SHALL occur when rd_water_level >= START_LEVEL and rd_empty==0; no reads SHALL be issued in IDLE.
REQ-019 RUN SHALL persist until flush or reset; FIFO running empty in RUN SHALL NOT leave RUN.
REQ-020 Internal word buffer SHALL be 2 entries x 32 bits; occupancy plus in-flight reads SHALL never exceed 2.
REQ-021 rd_en SHALL equal (state==RUN) and !rd_empty and (occupancy + inflight - pop_this_cycle < 2); rd_en SHALL never assert while rd_empty==1.
REQ-022 Data returning 1 cycle after rd_en SHALL be written to the buffer tail on that cycle.
REQ-023 pix_valid SHALL be high whenever buffer occupancy > 0; pix_data SHALL be head[15:0] when half==0, head[31:16] when half==1.
REQ-024 Transfer occurs when pix_valid && pix_ready; on transfer with half==0, half SHALL become 1; with half==1, half SHALL become 0 and the head word SHALL pop.
REQ-025 pix_data and pix_valid SHALL be held stable while pix_valid && !pix_ready.
REQ-026 Simultaneous pop and returning write SHALL be handled in the same cycle without loss or duplication.
REQ-027 With pix_ready held high and FIFO never empty, throughput SHALL be one pixel per cycle sustained.
REQ-028 Underflow event: state==RUN, pix_ready==1, pix_valid==0; each such cycle SHALL set underflow and increment underflow_cnt, saturating at 16'hFFFF.
REQ-029 flush SHALL in the next cycle: clear buffer, half=0, state=IDLE, clear underflow and underflow_cnt; a read returning in the cycle after flush SHALL be discarded.
REQ-030 flush has priority over all other events in the same cycle, including IDLE->RUN.
REQ-031 Outputs are registered except rd_en and pix_data/pix_valid muxing off registered buffer state.

Reset
REQ-032 During rd_rst: state=IDLE, rd_en=0, pix_valid=0, pix_data=16'h0000, running=0, underflow=0, underflow_cnt=0, buffer empty, half=0, inflight=0.
REQ-033 Reset deassertion SHALL be released on rd_clk; first possible rd_en is the first cycle after release in which REQ-018 is met and the state has become RUN.
REQ-034 Reset asserted mid-operation SHALL discard all buffered and in-flight data immediately.

Verification
REQ-035 Level gate: water level 15 with rd_empty=0 -> rd_en stays 0, running=0; level 16 -> running=1 next cycle, rd_en pulses follow.
REQ-036 Order: FIFO words 32'h2222_1111, 32'h4444_3333, pix_ready=1 -> pix_data 1111, 2222, 3333, 4444 on consecutive cycles.
REQ-037 Backpressure: pix_ready toggled randomly, 1000 words -> 2000 pixels in order, no loss/duplication, rd_en never while rd_empty=1, buffer never exceeds 2.
REQ-038 Underflow: RUN, FIFO empties, pix_ready=1 for 5 cycles with no data -> underflow=1, underflow_cnt=5; flush -> both 0, running=0.
REQ-039 Flush with read in flight: flush asserted the cycle rd_en=1 -> returned word discarded, pix_valid=0 next cycle, no stale pixel after restart.
REQ-040 Async reset mid-stream with pix_valid=1 -> pix_valid, rd_en, running go 0 without a clock edge; counter saturation forced at 16'hFFFF stays 16'hFFFF.

Source files
------------

// File: rtl/fifo_rd_unpack_32to16.sv
// Read-side unpacker: drains 32-bit words from a FIFO with a one-cycle read
// latency and presents them as a valid/ready stream of 16-bit pixels, low
// half first. A two-word skid buffer absorbs the read latency. Because the
// read issue accounts for the word in flight, one pixel per cycle is sustained.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no reads issued; waiting for the FIFO to reach START_LEVEL words
// RUN   | streaming; stays here on FIFO empty; left only by flush or reset
module fifo_rd_unpack_32to16 #(
  parameter int RD_DEPTH_WIDTH = 11,
  parameter int START_LEVEL    = 16
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  output logic                      rd_en,
  input  logic [31:0]               rd_data,
  input  logic                      rd_empty,
  input  logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  input  logic                      flush,
  input  logic                      pix_ready,
  output logic                      pix_valid,
  output logic [15:0]               pix_data,
  output logic                      running,
  output logic                      underflow,
  output logic [15:0]               underflow_cnt
);

  localparam logic [RD_DEPTH_WIDTH:0] START_LVL = (RD_DEPTH_WIDTH + 1)'(START_LEVEL);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] buf_mem0;
  logic [31:0] buf_mem1;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        half;
  logic        inflight;
  logic [1:0]  occ;

  logic [31:0] head;
  logic        xfer;
  logic        pop;
  logic        start;
  logic        under_evt;
  logic [2:0]  committed;

  // Buffer view and handshake decode, all off registered state
  assign head      = rd_ptr ? buf_mem1 : buf_mem0;
  assign pix_valid = (occ != 2'd0);
  assign pix_data  = pix_valid ? (half ? head[31:16] : head[15:0]) : 16'h0000;
  assign xfer      = pix_valid && pix_ready;
  assign pop       = xfer && half;

  // Words owned after this cycle: buffered plus returning minus popped.
  // This is also exactly the next occupancy.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // Read only while there is guaranteed room for the word one cycle later
  assign rd_en = (state == RUN) && !rd_empty && (committed < 3'd2);

  assign start     = (rd_water_level >= START_LVL) && !rd_empty;
  assign under_evt = (state == RUN) && pix_ready && !pix_valid;

  // Control FSM, buffer pointers, occupancy and underflow statistics
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state         <= IDLE;
      running       <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      half          <= 1'b0;
      inflight      <= 1'b0;
      occ           <= 2'd0;
      underflow     <= 1'b0;
      underflow_cnt <= 16'h0000;
    end else if (flush) begin
      // A read issued this cycle is forgotten, so its data is never written
      state         <= IDLE;
      running       <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      half          <= 1'b0;
      inflight      <= 1'b0;
      occ           <= 2'd0;
      underflow     <= 1'b0;
      underflow_cnt <= 16'h0000;
    end else begin
      if (state == IDLE) begin
        if (start) begin
          state   <= RUN;
          running <= 1'b1;
        end
      end

      inflight <= rd_en;

      if (inflight) begin
        wr_ptr <= ~wr_ptr;
      end

      if (xfer) begin
        half <= ~half;
        if (half) begin
          rd_ptr <= ~rd_ptr;
        end
      end

      occ <= committed[1:0];

      if (under_evt) begin
        underflow <= 1'b1;
        if (underflow_cnt != 16'hFFFF) begin
          underflow_cnt <= underflow_cnt + 16'd1;
        end
      end
    end
  end

  // Capture of returning read data into the buffer tail
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      buf_mem0 <= 32'h0000_0000;
      buf_mem1 <= 32'h0000_0000;
    end else if (!flush && inflight) begin
      if (wr_ptr) begin
        buf_mem1 <= rd_data;
      end else begin
        buf_mem0 <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_unpack_32to16.sv
// Bench for fifo_rd_unpack_32to16: behavioural FIFO with one-cycle read
// latency, expected-pixel scoreboard fed at push time, monitor that pops
// and compares on every accepted pixel.
module tb_fifo_rd_unpack_32to16;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        rd_en;
  logic [31:0] rd_data = 32'hDEAD_BEEF;
  logic        rd_empty = 1'b1;
  logic [11:0] rd_water_level = 12'd0;
  logic        flush = 1'b0;
  logic        pix_ready = 1'b0;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        running;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] fifo_q[$];
  logic [15:0] exp_q[$];

  bit          pop_now = 1'b0;
  logic [31:0] pop_word = 32'h0;
  bit          rd_en_seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;

  fifo_rd_unpack_32to16 #(
    .RD_DEPTH_WIDTH(11),
    .START_LEVEL(16)
  ) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_empty(rd_empty),
    .rd_water_level(rd_water_level),
    .flush(flush),
    .pix_ready(pix_ready),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .running(running),
    .underflow(underflow),
    .underflow_cnt(underflow_cnt)
  );

  always #10 rd_clk = ~rd_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w[15:0]);
    exp_q.push_back(w[31:16]);
  endtask

  task automatic do_flush();
    @(negedge rd_clk);
    flush = 1'b1;
    exp_q.delete();
    @(negedge rd_clk);
    flush = 1'b0;
    #6;
    check("flush_underflow", 32'(underflow), 32'd0);
    check("flush_cnt", 32'(underflow_cnt), 32'd0);
    check("flush_running", 32'(running), 32'd0);
  endtask

  // FIFO flags follow the queue, updated between edges
  always @(negedge rd_clk) begin
    #1;
    rd_empty = (fifo_q.size() == 0);
    rd_water_level = 12'(fifo_q.size());
  end

  // Read data appears one cycle after the rd_en cycle; garbage otherwise
  always @(posedge rd_clk) begin
    rd_data <= pop_now ? pop_word : 32'hDEAD_BEEF;
  end

  // Pre-edge sampler: FIFO pop and scoreboard monitor
  always @(negedge rd_clk) begin
    #5;
    pop_now = 1'b0;
    if (rd_en) begin
      rd_en_seen = 1'b1;
      check("rd_en_while_empty", 32'(rd_empty), 32'd0);
      if (fifo_q.size() > 0) begin
        pop_word = fifo_q.pop_front();
        pop_now = 1'b1;
      end
    end
    if (rd_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(pix_valid), 32'd1);
        check("stall_data", 32'(pix_data), 32'(prev_data));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got %h, expected none", pix_data);
        end else begin
          check("pixel", 32'(pix_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = pix_valid && !pix_ready && !flush;
      prev_data = pix_data;
    end
  end

  initial begin
    logic [15:0] order_exp [4];
    bit done;
    order_exp[0] = 16'h1111;
    order_exp[1] = 16'h2222;
    order_exp[2] = 16'h3333;
    order_exp[3] = 16'h4444;

    // Reset values
    repeat (3) @(negedge rd_clk);
    #6;
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_cnt", 32'(underflow_cnt), 32'd0);
    @(negedge rd_clk);
    rd_rst = 1'b0;

    // Level gate at 15 words, start at 16, then ordering
    @(negedge rd_clk);
    pix_ready = 1'b1;
    rd_en_seen = 1'b0;
    push(32'h2222_1111);
    push(32'h4444_3333);
    for (int i = 2; i < 15; i++) push(32'hA000_0000 + 32'(i * 16'h0101));
    repeat (6) @(negedge rd_clk);
    #6;
    check("gate15_running", 32'(running), 32'd0);
    check("gate15_rd_en_seen", 32'(rd_en_seen), 32'd0);
    @(negedge rd_clk);
    push(32'hB0B0_A0A0);
    @(negedge rd_clk);
    #6;
    check("gate16_running", 32'(running), 32'd1);
    check("gate16_rd_en", 32'(rd_en), 32'd1);
    @(negedge rd_clk);
    #6;
    check("latency_valid", 32'(pix_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      #6;
      check("order_valid", 32'(pix_valid), 32'd1);
      check("order_data", 32'(pix_data), 32'(order_exp[i]));
    end
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) begin done = 1'b1; break; end
      @(negedge rd_clk);
      #6;
    end
    if (!done) timeout("drain_t1");
    check("startup_cnt", 32'(underflow_cnt), 32'd2);
    check("startup_underflow", 32'(underflow), 32'd1);
    @(negedge rd_clk);
    pix_ready = 1'b0;
    do_flush();

    // Underflow counting and saturation
    @(negedge rd_clk);
    for (int i = 0; i < 16; i++) push(32'hC000_0000 + 32'(i));
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rd_clk);
      #6;
      if (running) begin done = 1'b1; break; end
    end
    if (!done) timeout("run_t2");
    repeat (4) @(negedge rd_clk);
    pix_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #6;
      if (exp_q.size() == 0) begin done = 1'b1; break; end
      @(negedge rd_clk);
    end
    if (!done) timeout("drain_t2");
    check("sustained_no_underflow", 32'(underflow_cnt), 32'd0);
    @(negedge rd_clk);
    pix_ready = 1'b0;
    repeat (5) begin
      @(negedge rd_clk);
      pix_ready = 1'b1;
    end
    @(negedge rd_clk);
    pix_ready = 1'b0;
    #6;
    check("underflow_flag", 32'(underflow), 32'd1);
    check("underflow_cnt5", 32'(underflow_cnt), 32'd5);
    force dut.underflow_cnt = 16'hFFFD;
    #1;
    release dut.underflow_cnt;
    repeat (4) begin
      @(negedge rd_clk);
      pix_ready = 1'b1;
    end
    @(negedge rd_clk);
    pix_ready = 1'b0;
    #6;
    check("cnt_saturate", 32'(underflow_cnt), 32'h0000_FFFF);
    do_flush();

    // Flush while a read is in flight
    @(negedge rd_clk);
    for (int i = 0; i < 15; i++) push(32'hD000_0000 + 32'(i));
    repeat (2) @(negedge rd_clk);
    @(negedge rd_clk);
    push(32'hD000_00FF);
    @(negedge rd_clk);
    flush = 1'b1;
    #6;
    check("flush_cycle_rd_en", 32'(rd_en), 32'd1);
    check("flush_cycle_running", 32'(running), 32'd1);
    exp_q.delete();
    @(negedge rd_clk);
    flush = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    #6;
    check("post_flush_valid", 32'(pix_valid), 32'd0);
    check("post_flush_running", 32'(running), 32'd0);
    @(negedge rd_clk);
    #6;
    check("discard_valid", 32'(pix_valid), 32'd0);
    @(negedge rd_clk);
    pix_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(32'hE000_0000 + 32'(i * 3));
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #6;
      if (exp_q.size() == 0) begin done = 1'b1; break; end
      @(negedge rd_clk);
    end
    if (!done) timeout("drain_t3");
    @(negedge rd_clk);
    pix_ready = 1'b0;
    do_flush();

    // Random backpressure over 1000 words
    @(negedge rd_clk);
    for (int i = 0; i < 1000; i++) push($urandom);
    done = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge rd_clk);
      pix_ready = 1'($urandom_range(0, 1));
      #6;
      if (exp_q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) timeout("drain_random");
    @(negedge rd_clk);
    pix_ready = 1'b0;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) push(32'hF000_0000 + 32'(i));
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rd_clk);
      #6;
      if (pix_valid) begin done = 1'b1; break; end
    end
    if (!done) timeout("valid_t5");
    #1;
    rd_rst = 1'b1;
    #1;
    check("arst_pix_valid", 32'(pix_valid), 32'd0);
    check("arst_rd_en", 32'(rd_en), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_pix_data", 32'(pix_data), 32'd0);
    check("arst_cnt", 32'(underflow_cnt), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(negedge rd_clk);
    rd_rst = 1'b0;
    repeat (2) @(negedge rd_clk);
    #6;
    check("post_rst_running", 32'(running), 32'd0);
    check("post_rst_valid", 32'(pix_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
